// File: rtl/data_cache_refill_ctrl.sv
// Data-cache miss controller: stalls the pipeline on a miss, writes back the
// valid lanes of the victim word, fetches the missing word and refills the cache.
package data_cache_refill_pkg;
    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_BYTE = 2'd1,
        WR_HALF = 2'd2,
        WR_WORD = 2'd3
    } CacheWrControl;
endpackage

module data_cache_refill_ctrl
    import data_cache_refill_pkg::*;
#(
    parameter  int CACHE_SIZE = 1024,
    localparam int IDX_W      = $clog2(CACHE_SIZE),
    localparam int TAG_W      = 32 - IDX_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                access_valid,
    input  logic [31:0]         access_addr,
    input  logic [3:0]          cache_miss,
    input  logic [TAG_W-1:0]    cache_tag,
    input  logic [3:0]          cache_valid,
    input  logic [31:0]         cache_rd_data,
    output logic                data_cache_stall,
    output CacheWrControl       data_cache_wr_en,
    output logic [31:0]         data_cache_addr,
    output logic [31:0]         data_cache_wr_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [3:0]          mem_byte_en,
    output logic [31:0]         mem_wr_data,
    input  logic [31:0]         mem_rd_data,
    input  logic                mem_ack,
    output logic [31:0]         miss_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] miss_addr;
    logic        miss;

    assign miss             = access_valid & (|cache_miss);
    assign data_cache_stall = (state != IDLE) | miss;

    // Memory and cache-port outputs are loaded with the values of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            miss_addr          <= '0;
            miss_count         <= '0;
            mem_req            <= 1'b0;
            mem_we             <= 1'b0;
            mem_addr           <= '0;
            mem_byte_en        <= '0;
            mem_wr_data        <= '0;
            data_cache_wr_en   <= WR_NONE;
            data_cache_addr    <= '0;
            data_cache_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        miss_addr  <= access_addr & 32'hFFFF_FFFC;
                        miss_count <= miss_count + 32'd1;
                        mem_req    <= 1'b1;
                        if (|cache_valid) begin
                            state       <= WRITEBACK;
                            mem_we      <= 1'b1;
                            mem_addr    <= {cache_tag, access_addr[IDX_W-1:2], 2'b00};
                            mem_byte_en <= cache_valid;
                            mem_wr_data <= cache_rd_data;
                        end else begin
                            state       <= FETCH;
                            mem_we      <= 1'b0;
                            mem_addr    <= access_addr & 32'hFFFF_FFFC;
                            mem_byte_en <= 4'hF;
                            mem_wr_data <= '0;
                        end
                    end
                end
                WRITEBACK: begin
                    // Request stays up; the write's ack is consumed here, never by the read.
                    if (mem_ack) begin
                        state       <= FETCH;
                        mem_we      <= 1'b0;
                        mem_addr    <= miss_addr;
                        mem_byte_en <= 4'hF;
                        mem_wr_data <= '0;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        state              <= FILL;
                        mem_req            <= 1'b0;
                        mem_we             <= 1'b0;
                        mem_addr           <= '0;
                        mem_byte_en        <= '0;
                        mem_wr_data        <= '0;
                        data_cache_wr_en   <= WR_WORD;
                        data_cache_addr    <= miss_addr;
                        data_cache_wr_data <= mem_rd_data;
                    end
                end
                FILL: begin
                    state              <= IDLE;
                    data_cache_wr_en   <= WR_NONE;
                    data_cache_addr    <= '0;
                    data_cache_wr_data <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_refill_ctrl.sv
// Scoreboard bench for data_cache_refill_ctrl: expected memory transactions and
// cache fills are queued by the stimulus and checked by an independent monitor.
module tb_data_cache_refill_ctrl;
    import data_cache_refill_pkg::*;

    localparam int TAG_W = 22;

    logic              clk;
    logic              reset;
    logic              access_valid;
    logic [31:0]       access_addr;
    logic [3:0]        cache_miss;
    logic [TAG_W-1:0]  cache_tag;
    logic [3:0]        cache_valid;
    logic [31:0]       cache_rd_data;
    logic              data_cache_stall;
    CacheWrControl     data_cache_wr_en;
    logic [31:0]       data_cache_addr;
    logic [31:0]       data_cache_wr_data;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [3:0]        mem_byte_en;
    logic [31:0]       mem_wr_data;
    logic [31:0]       mem_rd_data;
    logic              mem_ack;
    logic [31:0]       miss_count;

    data_cache_refill_ctrl #(.CACHE_SIZE(1024)) dut (
        .clk                (clk),
        .reset              (reset),
        .access_valid       (access_valid),
        .access_addr        (access_addr),
        .cache_miss         (cache_miss),
        .cache_tag          (cache_tag),
        .cache_valid        (cache_valid),
        .cache_rd_data      (cache_rd_data),
        .data_cache_stall   (data_cache_stall),
        .data_cache_wr_en   (data_cache_wr_en),
        .data_cache_addr    (data_cache_addr),
        .data_cache_wr_data (data_cache_wr_data),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_byte_en        (mem_byte_en),
        .mem_wr_data        (mem_wr_data),
        .mem_rd_data        (mem_rd_data),
        .mem_ack            (mem_ack),
        .miss_count         (miss_count)
    );

    localparam int K_WR = 0, K_RD = 1, K_FILL = 2;
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    // Memory model knobs, written by the stimulus process only.
    int          ack_lat;
    bit          ack_hold;
    logic [31:0] rd_word;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] data);
        exp_t e;
        e.kind = kind; e.addr = addr; e.be = be; e.data = data;
        exp_q.push_back(e);
    endtask

    // Memory responder: acks ack_lat cycles into a request, or holds ack high.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(negedge clk);
            if (ack_hold) begin
                mem_ack = 1'b1;
                mem_rd_data = rd_word;
                cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_req) begin
                cnt++;
                if (cnt >= ack_lat) begin
                    mem_ack = 1'b1;
                    mem_rd_data = rd_word;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every completed transaction and every fill.
    initial begin
        bit          prev_pending;
        logic [79:0] prev_fields;
        exp_t        e;
        prev_pending = 1'b0;
        prev_fields  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_pending = 1'b0;
            end else begin
                if (prev_pending)
                    check("mem_hold", {10'd0, mem_req, mem_we, mem_addr, mem_byte_en, mem_wr_data},
                          prev_fields);
                if (mem_req && mem_ack) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_mem: got we=%0b addr=%h, required no transaction",
                                 mem_we, mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("mem_kind", mem_we ? K_WR : K_RD, e.kind);
                        check("mem_addr", mem_addr, e.addr);
                        check("mem_byte_en", mem_byte_en, e.be);
                        if (mem_we) check("mem_wr_data", mem_wr_data, e.data);
                    end
                end
                if (data_cache_wr_en != WR_NONE) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_fill: got addr=%h data=%h, required no fill",
                                 data_cache_addr, data_cache_wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("fill_kind", K_FILL, e.kind);
                        check("fill_wr_en", data_cache_wr_en, WR_WORD);
                        check("fill_addr", data_cache_addr, e.addr);
                        check("fill_data", data_cache_wr_data, e.data);
                    end
                end
                prev_pending = mem_req && !mem_ack;
                prev_fields  = {10'd0, mem_req, mem_we, mem_addr, mem_byte_en, mem_wr_data};
            end
        end
    end

    task automatic clear_access();
        access_valid = 1'b0; access_addr = '0; cache_miss = '0;
        cache_tag = '0; cache_valid = '0; cache_rd_data = '0;
    endtask

    // Presents one access for a cycle and counts stalled cycles until stall drops.
    task automatic run_access(input logic [31:0] addr, input logic [3:0] miss,
                              input logic [TAG_W-1:0] tag, input logic [3:0] vld,
                              input logic [31:0] rdata, output int n, output int fill_cyc);
        @(negedge clk);
        access_valid = 1'b1; access_addr = addr; cache_miss = miss;
        cache_tag = tag; cache_valid = vld; cache_rd_data = rdata;
        n = 0;
        fill_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (data_cache_wr_en == WR_WORD && fill_cyc < 0) fill_cyc = c;
            if (!data_cache_stall) break;
            n++;
            @(negedge clk);
            clear_access();
        end
        clear_access();
    endtask

    initial begin
        int n, fc;
        vectors = 0;
        miscompares = 0;
        ack_lat = 2;
        ack_hold = 1'b0;
        rd_word = '0;
        reset = 1'b1;
        clear_access();

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_stall", data_cache_stall, 1'b0);
        check("rst_wr_en", data_cache_wr_en, WR_NONE);
        check("rst_cache_addr", data_cache_addr, 32'h0);
        check("rst_cache_data", data_cache_wr_data, 32'h0);
        check("rst_mem_req", {mem_req, mem_we, mem_byte_en}, 6'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wr_data", mem_wr_data, 32'h0);
        check("rst_miss_count", miss_count, 32'h0);

        // Clean miss, ack on the second request cycle.
        ack_lat = 2;
        rd_word = 32'hDEAD_BEEF;
        push(K_RD, 32'h0000_1234, 4'hF, 32'h0);
        push(K_FILL, 32'h0000_1234, 4'h0, 32'hDEAD_BEEF);
        run_access(32'h0000_1236, 4'hF, '0, 4'h0, 32'h0, n, fc);
        check("clean_stall_len", n, 4);
        check("clean_fill_cycle", fc, 3);
        check("clean_miss_count", miss_count, 32'd1);

        // Dirty miss: write back lanes 0 and 2, then read, then fill.
        ack_lat = 2;
        rd_word = 32'h1234_5678;
        push(K_WR, 32'h0000_0408, 4'b0101, 32'hA5A5_A5A5);
        push(K_RD, 32'h0000_0808, 4'hF, 32'h0);
        push(K_FILL, 32'h0000_0808, 4'h0, 32'h1234_5678);
        run_access(32'h0000_0808, 4'b0010, 22'h1, 4'b0101, 32'hA5A5_A5A5, n, fc);
        check("dirty_stall_len", n, 7);
        check("dirty_miss_count", miss_count, 32'd2);

        // Zero-wait memory: ack held high throughout.
        ack_hold = 1'b1;
        rd_word = 32'hCAFE_F00D;
        push(K_RD, 32'h0000_0040, 4'hF, 32'h0);
        push(K_FILL, 32'h0000_0040, 4'h0, 32'hCAFE_F00D);
        run_access(32'h0000_0043, 4'h1, '0, 4'h0, 32'h0, n, fc);
        ack_hold = 1'b0;
        check("zw_stall_len", n, 3);
        check("zw_fill_cycle", fc, 2);
        check("zw_miss_count", miss_count, 32'd3);

        // Reset asserted while the fetch is outstanding.
        ack_lat = 20;
        @(negedge clk);
        access_valid = 1'b1; access_addr = 32'h0000_0200; cache_miss = 4'hF;
        @(negedge clk);
        clear_access();
        repeat (2) @(negedge clk);
        #1;
        check("mid_fetch_req", mem_req, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_req", mem_req, 1'b0);
        check("async_rst_stall", data_cache_stall, 1'b0);
        check("async_rst_count", miss_count, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        ack_lat = 1;
        rd_word = 32'h0BAD_F00D;
        push(K_RD, 32'h0000_0104, 4'hF, 32'h0);
        push(K_FILL, 32'h0000_0104, 4'h0, 32'h0BAD_F00D);
        run_access(32'h0000_0104, 4'h8, '0, 4'h0, 32'h0, n, fc);
        check("post_rst_stall_len", n, 3);
        check("post_rst_miss_count", miss_count, 32'd1);

        // Miss flags without access_valid, plus acks while idle.
        ack_hold = 1'b1;
        rd_word = 32'hFFFF_FFFF;
        @(negedge clk);
        access_valid = 1'b0; cache_miss = 4'hF; cache_valid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("spur_stall", data_cache_stall, 1'b0);
            check("spur_req", mem_req, 1'b0);
            @(negedge clk);
        end
        ack_hold = 1'b0;
        clear_access();
        repeat (2) @(negedge clk);
        #1;
        check("spur_miss_count", miss_count, 32'd1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
